// File: rtl/plic_claim_ctrl_if.sv
// rtl/plic_claim_ctrl_if.sv - register bus shared by the CPU and PLIC sides of plic_claim_ctrl.
interface plic_claim_ctrl_if;
    logic        stb;
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  byte_sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;

    modport master (output stb, we, adr, byte_sel, wdat, input rdat);
    modport slave  (input stb, we, adr, byte_sel, wdat, output rdat, ack);
endinterface

// File: rtl/plic_claim_ctrl.sv
// rtl/plic_claim_ctrl.sv - PLIC claim/complete engine with CPU register pass-through.
// Optional HOLD watchdog enabled by macro PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ID_W           = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    plic_claim_ctrl_if.slave      cpu,
    plic_claim_ctrl_if.master     plic,
    input  logic                  plic_irq_i,
    input  logic                  irq_done_i,
    output logic                  ext_irq_o,
    output logic [ID_W-1:0]       irq_id_o,
    output logic                  irq_id_valid_o,
    output logic [7:0]            spurious_cnt_o,
    output logic                  timeout_o
);
    localparam logic [9:0] CLAIM_ADR = 10'h204;

    if (TIMEOUT_CYCLES < 1 || ID_W < 1 || ID_W > 32) begin : g_bad_cfg
        $error("plic_claim_ctrl: unsupported TIMEOUT_CYCLES/ID_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_CLAIM, S_HOLD, S_COMPLETE} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            valid_q, valid_d;
    logic [7:0]      spur_q, spur_d;
    logic [ID_W-1:0] claim_id;
    logic            tmo_fire;

    assign claim_id = plic.rdat[ID_W-1:0];

`ifdef PLIC_CLAIM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    assign tmo_fire = (state_q == S_HOLD) && (hold_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        hold_cnt_d = '0;
        timeout_d  = timeout_q;
        if (state_q == S_HOLD && state_d == S_HOLD) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        // A done pulse on the deadline cycle wins over the watchdog.
        if (tmo_fire && !irq_done_i) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            valid_q <= 1'b0;
            spur_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            spur_q  <= spur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        spur_d  = spur_q;
        case (state_q)
            S_IDLE: begin
                if (plic_irq_i) state_d = S_CLAIM;
            end
            S_CLAIM: begin
                id_d = claim_id;
                if (claim_id != '0) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (spur_q != 8'hFF) spur_d = spur_q + 8'h01;
                end
            end
            S_HOLD: begin
                if (irq_done_i || tmo_fire) state_d = S_COMPLETE;
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine owns the PLIC port in CLAIM/COMPLETE; otherwise the CPU passes through.
    always_comb begin
        plic.stb      = 1'b0;
        plic.we       = 1'b0;
        plic.adr      = '0;
        plic.byte_sel = '0;
        plic.wdat     = '0;
        cpu.rdat      = '0;
        cpu.ack       = 1'b0;
        if (state_q == S_CLAIM) begin
            plic.stb      = 1'b1;
            plic.adr      = CLAIM_ADR;
            plic.byte_sel = 4'hF;
        end else if (state_q == S_COMPLETE) begin
            plic.stb      = 1'b1;
            plic.we       = 1'b1;
            plic.adr      = CLAIM_ADR;
            plic.byte_sel = 4'hF;
            plic.wdat     = 32'(id_q);
        end else if (cpu.stb) begin
            cpu.ack = 1'b1;
            if (cpu.adr == CLAIM_ADR) begin
                if (!cpu.we && valid_q) cpu.rdat = 32'(id_q);
            end else begin
                plic.stb      = 1'b1;
                plic.we       = cpu.we;
                plic.adr      = cpu.adr;
                plic.byte_sel = cpu.byte_sel;
                plic.wdat     = cpu.wdat;
                if (!cpu.we) cpu.rdat = plic.rdat;
            end
        end
    end

    assign irq_id_o       = id_q;
    assign irq_id_valid_o = valid_q;
    assign ext_irq_o      = valid_q;
    assign spurious_cnt_o = spur_q;
endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb/tb_plic_claim_ctrl.sv - self-checking bench for plic_claim_ctrl.
module tb_plic_claim_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       plic_irq, irq_done;
    logic       ext_irq, id_valid, timeout;
    logic [4:0] irq_id;
    logic [7:0] spur;
    logic [4:0] claim_val;
    int         total = 0;
    int         bad   = 0;
    int         exp_spur = 0;
    logic [46:0] log_q[$];

    always #5 clk = ~clk;

    plic_claim_ctrl_if cpu_bus ();
    plic_claim_ctrl_if plic_bus ();

    plic_claim_ctrl #(.TIMEOUT_CYCLES(16), .ID_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .cpu(cpu_bus), .plic(plic_bus),
        .plic_irq_i(plic_irq), .irq_done_i(irq_done), .ext_irq_o(ext_irq),
        .irq_id_o(irq_id), .irq_id_valid_o(id_valid), .spurious_cnt_o(spur),
        .timeout_o(timeout)
    );

    function automatic logic [31:0] reg_val(logic [9:0] a);
        return {a, 12'h5A3, a};
    endfunction

    function automatic logic [46:0] ent(logic we, logic [31:0] d);
        return {we, 10'h204, 4'hF, d};
    endfunction

    // PLIC model: claim register returns claim_val, everything else a fixed pattern.
    always_comb plic_bus.rdat = (plic_bus.adr == 10'h204) ? {27'b0, claim_val} : reg_val(plic_bus.adr);
    assign plic_bus.ack = plic_bus.stb;

    always @(posedge clk) begin
        if (!rst && plic_bus.stb && plic_bus.adr == 10'h204)
            log_q.push_back({plic_bus.we, plic_bus.adr, plic_bus.byte_sel, plic_bus.wdat});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_bus.stb = 1'b0; cpu_bus.we = 1'b0; cpu_bus.adr = '0;
        cpu_bus.byte_sel = '0; cpu_bus.wdat = '0;
    endtask

    task automatic cpu_read(logic [9:0] a);
        cpu_bus.stb = 1'b1; cpu_bus.we = 1'b0; cpu_bus.adr = a;
        cpu_bus.byte_sel = 4'hF; cpu_bus.wdat = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; plic_irq = 1'b0; irq_done = 1'b0; claim_val = '0;
        cpu_idle();
        tick(); tick();
        #3;
        total++;
        if ({ext_irq, id_valid, irq_id, spur, timeout, plic_bus.stb, cpu_bus.rdat} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ext=%b v=%b id=%0d spur=%0d to=%b stb=%b rdat=%h want all 0",
                     ext_irq, id_valid, irq_id, spur, timeout, plic_bus.stb, cpu_bus.rdat);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_claim_complete(int n);
        logic [4:0] id;
        int w;
        for (int i = 0; i < n; i++) begin
            id = (i == 0) ? 5'd7 : 5'($urandom_range(1, 31));
            claim_val = id;
            log_q.delete();
            plic_irq = 1'b1;
            tick();
            plic_irq = 1'b0;
            #3;
            total++;
            if ({plic_bus.stb, plic_bus.we, plic_bus.adr, plic_bus.byte_sel, ext_irq} !== {1'b1, 1'b0, 10'h204, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL claim_read got stb=%b we=%b adr=%h sel=%h ext=%b want 1 0 204 f 0",
                         plic_bus.stb, plic_bus.we, plic_bus.adr, plic_bus.byte_sel, ext_irq);
            end
            tick();
            #3;
            total++;
            if ({ext_irq, id_valid, irq_id} !== {1'b1, 1'b1, id}) begin
                bad++;
                $display("FAIL claim_valid got ext=%b v=%b id=%0d want 1 1 %0d", ext_irq, id_valid, irq_id, id);
            end
            w = $urandom_range(0, 4);
            for (int k = 0; k < w; k++) tick();
            irq_done = 1'b1;
            tick();
            irq_done = 1'b0;
            #3;
            total++;
            if ({plic_bus.stb, plic_bus.we, plic_bus.adr, plic_bus.byte_sel, plic_bus.wdat} !== {1'b1, 1'b1, 10'h204, 4'hF, 32'(id)}) begin
                bad++;
                $display("FAIL complete_write got stb=%b we=%b adr=%h sel=%h dat=%h want 1 1 204 f %h",
                         plic_bus.stb, plic_bus.we, plic_bus.adr, plic_bus.byte_sel, plic_bus.wdat, 32'(id));
            end
            tick();
            #3;
            total++;
            if ({ext_irq, id_valid, plic_bus.stb} !== 3'b000) begin
                bad++;
                $display("FAIL after_complete got ext=%b v=%b stb=%b want 0 0 0", ext_irq, id_valid, plic_bus.stb);
            end
            total++;
            if (log_q.size() != 2 || log_q[0] !== ent(1'b0, 32'h0) || log_q[1] !== ent(1'b1, 32'(id))) begin
                bad++;
                $display("FAIL claim_log got size=%0d want 2 (read, write id %0d)", log_q.size(), id);
            end
        end
    endtask

    task automatic test_spurious(int n);
        int e;
        claim_val = '0;
        for (int k = 1; k <= n; k++) begin
            plic_irq = 1'b1;
            tick();
            plic_irq = 1'b0;
            tick();
            #3;
            e = exp_spur + k;
            if (e > 255) e = 255;
            total++;
            if (spur !== 8'(e) || ext_irq !== 1'b0) begin
                bad++;
                $display("FAIL spurious_%0d got cnt=%0d ext=%b want %0d 0", k, spur, ext_irq, e);
            end
        end
        exp_spur = (exp_spur + n > 255) ? 255 : exp_spur + n;
        total++;
        if (n >= 255 && spur !== 8'hFF) begin
            bad++;
            $display("FAIL spurious_saturate got %0d want 255", spur);
        end
    endtask

    task automatic test_cpu_passthrough(int n);
        logic [9:0]  a;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            a = 10'($urandom_range(0, 1023));
            if (a == 10'h204) a = 10'h100;
            we = 1'($urandom_range(0, 1)); sel = 4'($urandom); d = $urandom;
            cpu_bus.stb = 1'b1; cpu_bus.we = we; cpu_bus.adr = a; cpu_bus.byte_sel = sel; cpu_bus.wdat = d;
            #3;
            total++;
            if ({cpu_bus.ack, plic_bus.stb, plic_bus.we, plic_bus.adr, plic_bus.byte_sel, plic_bus.wdat} !== {2'b11, we, a, sel, d} ||
                cpu_bus.rdat !== (we ? 32'h0 : reg_val(a))) begin
                bad++;
                $display("FAIL passthrough adr=%h we=%b got ack=%b stb=%b padr=%h sel=%h wd=%h rd=%h",
                         a, we, cpu_bus.ack, plic_bus.stb, plic_bus.adr, plic_bus.byte_sel, plic_bus.wdat, cpu_bus.rdat);
            end
            tick();
        end
        cpu_read(10'h204);
        #3;
        total++;
        if ({cpu_bus.ack, plic_bus.stb, cpu_bus.rdat} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL idle_claim_read got ack=%b stb=%b rd=%h want 1 0 0", cpu_bus.ack, plic_bus.stb, cpu_bus.rdat);
        end
        tick();
        cpu_idle();
        #3;
        total++;
        if ({cpu_bus.ack, plic_bus.stb, cpu_bus.rdat} !== '0) begin
            bad++;
            $display("FAIL no_request got ack=%b stb=%b rd=%h want 0", cpu_bus.ack, plic_bus.stb, cpu_bus.rdat);
        end
    endtask

    task automatic test_arbitration();
        claim_val = 5'd3;
        log_q.delete();
        plic_irq = 1'b1;
        cpu_read(10'h0F0);
        #3;
        total++;
        if (cpu_bus.ack !== 1'b1 || cpu_bus.rdat !== reg_val(10'h0F0)) begin
            bad++;
            $display("FAIL irq_and_cpu got ack=%b rd=%h want 1 %h", cpu_bus.ack, cpu_bus.rdat, reg_val(10'h0F0));
        end
        tick();
        plic_irq = 1'b0;
        cpu_read(10'h100);
        #3;
        total++;
        if (cpu_bus.ack !== 1'b0 || plic_bus.adr !== 10'h204) begin
            bad++;
            $display("FAIL cpu_stall_claim got ack=%b padr=%h want 0 204", cpu_bus.ack, plic_bus.adr);
        end
        tick();
        #3;
        total++;
        if (cpu_bus.ack !== 1'b1 || cpu_bus.rdat !== reg_val(10'h100) || plic_bus.adr !== 10'h100) begin
            bad++;
            $display("FAIL cpu_after_claim got ack=%b rd=%h padr=%h", cpu_bus.ack, cpu_bus.rdat, plic_bus.adr);
        end
        tick();
        cpu_read(10'h204);
        #3;
        total++;
        if ({cpu_bus.ack, plic_bus.stb, cpu_bus.rdat} !== {2'b10, 32'h3}) begin
            bad++;
            $display("FAIL hold_claim_read got ack=%b stb=%b rd=%h want 1 0 3", cpu_bus.ack, plic_bus.stb, cpu_bus.rdat);
        end
        tick();
        cpu_bus.we = 1'b1; cpu_bus.wdat = $urandom;
        #3;
        total++;
        if ({cpu_bus.ack, plic_bus.stb} !== 2'b10) begin
            bad++;
            $display("FAIL hold_claim_write got ack=%b stb=%b want 1 0", cpu_bus.ack, plic_bus.stb);
        end
        tick();
        cpu_idle();
        #3;
        total++;
        if (irq_id !== 5'd3 || id_valid !== 1'b1) begin
            bad++;
            $display("FAIL id_kept got id=%0d v=%b want 3 1", irq_id, id_valid);
        end
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        cpu_read(10'h100);
        #3;
        total++;
        if (cpu_bus.ack !== 1'b0 || plic_bus.we !== 1'b1 || plic_bus.wdat !== 32'h3) begin
            bad++;
            $display("FAIL cpu_stall_complete got ack=%b we=%b wd=%h want 0 1 3", cpu_bus.ack, plic_bus.we, plic_bus.wdat);
        end
        tick();
        #3;
        total++;
        if (cpu_bus.ack !== 1'b1 || cpu_bus.rdat !== reg_val(10'h100)) begin
            bad++;
            $display("FAIL cpu_after_complete got ack=%b rd=%h", cpu_bus.ack, cpu_bus.rdat);
        end
        tick();
        cpu_idle();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        #3;
        total++;
        if (plic_bus.stb !== 1'b0 || ext_irq !== 1'b0 || log_q.size() != 2) begin
            bad++;
            $display("FAIL done_ignored got stb=%b ext=%b log=%0d want 0 0 2", plic_bus.stb, ext_irq, log_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] id;
        id = 5'($urandom_range(1, 31));
        claim_val = id;
        plic_irq = 1'b1;
        tick(); tick();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        #3;
        total++;
        if (plic_bus.stb !== 1'b0 || ext_irq !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle got stb=%b ext=%b want 0 0", plic_bus.stb, ext_irq);
        end
        tick();
        plic_irq = 1'b0;
        #3;
        total++;
        if ({plic_bus.stb, plic_bus.we, plic_bus.adr} !== {2'b10, 10'h204}) begin
            bad++;
            $display("FAIL reclaim got stb=%b we=%b adr=%h want 1 0 204", plic_bus.stb, plic_bus.we, plic_bus.adr);
        end
        tick();
        // Stay in HOLD long enough to show the watchdog behaviour of this build.
        log_q.delete();
        for (int k = 1; k <= 40; k++) begin
            if (log_q.size() != 0) break;
            tick();
        end
`ifdef PLIC_CLAIM_TIMEOUT_EN
        total++;
        if (log_q.size() != 1 || log_q[0] !== ent(1'b1, 32'(id)) || timeout !== 1'b1) begin
            bad++;
            $display("FAIL watchdog got log=%0d to=%b want 1 1", log_q.size(), timeout);
        end
`else
        total++;
        if (log_q.size() != 0 || timeout !== 1'b0 || ext_irq !== 1'b1) begin
            bad++;
            $display("FAIL hold_forever got log=%0d to=%b ext=%b want 0 0 1", log_q.size(), timeout, ext_irq);
        end
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_in_hold();
        claim_val = 5'd9;
        plic_irq = 1'b1;
        tick();
        plic_irq = 1'b0;
        tick();
        log_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        total++;
        if ({ext_irq, id_valid, irq_id, spur, timeout, plic_bus.stb} !== '0) begin
            bad++;
            $display("FAIL reset_hold got ext=%b v=%b id=%0d spur=%0d to=%b stb=%b want 0",
                     ext_irq, id_valid, irq_id, spur, timeout, plic_bus.stb);
        end
        exp_spur = 0;
        tick(); tick(); tick();
        total++;
        if (log_q.size() != 0) begin
            bad++;
            $display("FAIL reset_no_write got %0d writes want 0", log_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_claim_complete(8);
        test_spurious(300);
        test_cpu_passthrough(20);
        test_arbitration();
        test_back_to_back();
        test_reset_in_hold();
        test_claim_complete(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/plic_claim_ctrl.md
PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, HOLD-state watchdog limit in clocks (used only with PLIC_CLAIM_TIMEOUT_EN).
REQ-002 Parameter ID_W, default 5, interrupt ID width.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 cpu_stb_i / cpu_we_i  in  1 / 1  CPU register request and write flag.
REQ-006 cpu_adr_i / cpu_byte_sel_i / cpu_dat_i  in  10 / 4 / 32  CPU address, byte enables, write data.
REQ-007 cpu_dat_o / cpu_ack_o  out  32 / 1  CPU read data and grant; both are combinational.
REQ-008 plic_stb_o / plic_we_o  out  1 / 1  PLIC register request and write flag.
REQ-009 plic_adr_o / plic_byte_sel_o / plic_dat_o  out  10 / 4 / 32  PLIC address, byte enables, write data.
REQ-010 plic_dat_i / plic_irq_i  in  32 / 1  PLIC read data and PLIC interrupt request.
REQ-011 ext_irq_o  out  1  external interrupt to the core; equals irq_id_valid_o.
REQ-012 irq_id_o / irq_id_valid_o  out  ID_W / 1  latched claimed ID and its valid flag.
REQ-013 irq_done_i  in  1  one-cycle pulse from the core: handler finished.
REQ-014 spurious_cnt_o  out  8  saturating count of claims that returned ID 0.
REQ-015 timeout_o  out  1  sticky watchdog flag, cleared only by reset.

Function
REQ-016 The FSM SHALL have four states: IDLE, CLAIM, HOLD and COMPLETE.
REQ-017 IDLE: if plic_irq_i=1, the next state SHALL be CLAIM; otherwise the FSM stays in IDLE.
REQ-018 CLAIM: the engine SHALL drive a one-cycle read of 0x204 (plic_stb_o=1, plic_we_o=0, byte_sel=4'hF) and latch plic_dat_i[ID_W-1:0] at the clock edge.
REQ-019 CLAIM with a nonzero ID: next state HOLD, and irq_id_valid_o is set from the following cycle.
REQ-020 CLAIM with ID 0: next state IDLE and spurious_cnt_o increments, saturating at 8'hFF.
REQ-021 HOLD: irq_id_valid_o=1; on irq_done_i=1 the next state SHALL be COMPLETE.
REQ-022 COMPLETE: the engine SHALL drive a one-cycle write of 0x204 with zero-extended irq_id_o and byte_sel=4'hF; next state IDLE, and irq_id_valid_o clears.
REQ-023 Claim-to-valid latency SHALL be 2 cycles from plic_irq_i rising while in IDLE. The minimum gap between COMPLETE and the next CLAIM SHALL be 1 cycle (IDLE).
REQ-024 irq_done_i outside HOLD SHALL be ignored.
REQ-025 Arbitration: in CLAIM and COMPLETE the engine owns the PLIC port, cpu_ack_o=0, and the CPU must hold its request.
REQ-026 In IDLE and HOLD, a CPU request SHALL pass straight through to the PLIC with cpu_ack_o=cpu_stb_i in the same cycle.
REQ-027 A CPU access to 0x204 SHALL NOT be forwarded to the PLIC (plic_stb_o=0) and SHALL be acked.
REQ-028 A CPU read of 0x204 SHALL return {27'b0, irq_id_o} when valid, else 0. A CPU write to 0x204 SHALL be ignored.
REQ-029 When no request is active, plic_* outputs SHALL be 0 and cpu_dat_o SHALL be 0.
REQ-030 If plic_irq_i and cpu_stb_i are both high in IDLE, the CPU access completes that cycle and CLAIM follows.

Reset
REQ-031 Reset SHALL force state IDLE; irq_id_o, irq_id_valid_o, ext_irq_o, spurious_cnt_o and timeout_o all 0; no PLIC access.
REQ-032 Reset in CLAIM, HOLD or COMPLETE SHALL abandon the operation without issuing a COMPLETE write (the PLIC is reset with the system).

Configuration
REQ-033 Macro PLIC_CLAIM_TIMEOUT_EN defined: a HOLD-state counter counts cycles. When it reaches TIMEOUT_CYCLES without irq_done_i, the FSM goes to COMPLETE and sets timeout_o. The counter clears on leaving HOLD.
REQ-034 Macro PLIC_CLAIM_TIMEOUT_EN undefined: no counter, timeout_o is tied to 0, and HOLD waits indefinitely.

Verification
REQ-035 PLIC returns ID 7 on claim, plic_irq_i pulsed -> CLAIM read at 0x204, irq_id_o=7 and ext_irq_o=1 two cycles later.
REQ-036 irq_done_i pulsed in HOLD with ID 7 -> one write of 32'h7 to 0x204, then ext_irq_o=0.
REQ-037 Claim returns 0 -> state back to IDLE, spurious_cnt_o=1, ext_irq_o stays 0. After 300 spurious claims -> spurious_cnt_o=8'hFF.
REQ-038 CPU read of 0x100 issued during CLAIM -> cpu_ack_o=0 that cycle, ack next cycle with PLIC data. CPU read of 0x204 in HOLD with ID 3 -> 32'h3 returned and plic_stb_o=0.
REQ-039 With PLIC_CLAIM_TIMEOUT_EN and TIMEOUT_CYCLES=16, no irq_done_i -> COMPLETE write on the 16th HOLD cycle and timeout_o=1.
REQ-040 rst_i asserted in HOLD -> next cycle IDLE, all outputs 0, no COMPLETE write.
